// File: rtl/de_pkg.sv
// Shared types and constants for the dice roller.
// FSM states, LFSR definition and value widths.
package de_pkg;

  typedef enum logic [2:0] {
    ATTENTE,
    MODULO,
    SOMME,
    BCD,
    FINI
  } etat_t;

  localparam int LFSR_W = 16;
  // taps for x^16+x^14+x^13+x^11+1, left-shifting register
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  localparam int VAL_W = 7;
  localparam int FACES_MAX = 100;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bin_vers_bcd.sv
// Sequential double-dabble: 7-bit binary to three BCD digits.
// Outputs change only on the cycle the conversion completes.
module bin_vers_bcd
  import de_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             fini,
  output logic [3:0]       bcd100,
  output logic [3:0]       bcd10,
  output logic [3:0]       bcd1
);

  localparam int SH_W = 12 + VAL_W;

  logic [SH_W-1:0] r_sh;
  logic [2:0]      r_cnt;
  logic            r_busy;
  logic            r_fini;
  logic [3:0]      r_b100, r_b10, r_b1;
  logic [SH_W-1:0] w_next;

  always_comb begin
    w_next = r_sh;
    for (int n = 0; n < 3; n++) begin
      if (w_next[VAL_W+4*n +: 4] >= 4'd5)
        w_next[VAL_W+4*n +: 4] = w_next[VAL_W+4*n +: 4] + 4'd3;
    end
    w_next = w_next << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_fini <= 1'b0;
      r_b100 <= '0;
      r_b10  <= '0;
      r_b1   <= '0;
    end else begin
      r_fini <= 1'b0;
      if (start) begin
        r_sh   <= {12'd0, bin};
        r_cnt  <= 3'd7;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_sh  <= w_next;
        r_cnt <= r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          r_busy <= 1'b0;
          r_fini <= 1'b1;
          r_b100 <= w_next[VAL_W+8 +: 4];
          r_b10  <= w_next[VAL_W+4 +: 4];
          r_b1   <= w_next[VAL_W +: 4];
        end
      end
    end
  end

  assign fini   = r_fini;
  assign bcd100 = r_b100;
  assign bcd10  = r_b10;
  assign bcd1   = r_b1;

endmodule

// File: rtl/lancer_de.sv
// Dice roller: LFSR sample reduced modulo the face count,
// offset by the minimum face, then converted to BCD.
module lancer_de
  import de_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             lancer,
  input  logic [VAL_W-1:0] min_de,
  input  logic [VAL_W-1:0] faces_de,
  output logic [VAL_W-1:0] resultat,
  output logic [3:0]       bcd100,
  output logic [3:0]       bcd10,
  output logic [3:0]       bcd1,
  output logic             pret,
  output logic             occupe
);

  etat_t             r_etat;
  logic [LFSR_W-1:0] r_lfsr;
  logic              r_prev;
  logic [VAL_W-1:0]  r_min;
  logic [VAL_W-1:0]  r_faces;
  logic [7:0]        r_reste;
  logic [VAL_W-1:0]  r_res;
  logic              r_pret;

  logic             w_start;
  logic             w_go_bcd;
  logic             w_fini;
  logic [7:0]       w_faces;
  logic [VAL_W-1:0] w_sum;

  assign w_start  = (r_etat == ATTENTE) & lancer & ~r_prev;
  assign w_go_bcd = (r_etat == SOMME);
  assign w_faces  = {1'b0, r_faces};
  // low 7 bits of the 8-bit sum: the truncation is the same
  assign w_sum    = r_min + r_reste[VAL_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_etat  <= ATTENTE;
      r_lfsr  <= LFSR_SEED;
      r_prev  <= 1'b1;
      r_min   <= '0;
      r_faces <= '0;
      r_reste <= '0;
      r_res   <= '0;
      r_pret  <= 1'b0;
    end else begin
      r_prev <= lancer;
      r_lfsr <= lfsr_next(r_lfsr);
      unique case (r_etat)
        ATTENTE: begin
          if (w_start) begin
            r_min   <= min_de;
            r_faces <= faces_de;
            r_reste <= r_lfsr[7:0];
            r_pret  <= 1'b0;
            r_etat  <= MODULO;
          end
        end
        MODULO: begin
          if (r_faces == '0) begin
            r_reste <= '0;
            r_etat  <= SOMME;
          end else if (r_reste >= w_faces) begin
            r_reste <= r_reste - w_faces;
          end else begin
            r_etat <= SOMME;
          end
        end
        SOMME: begin
          r_res  <= w_sum;
          r_etat <= BCD;
        end
        BCD: begin
          if (w_fini) begin
            r_pret <= 1'b1;
            r_etat <= FINI;
          end
        end
        FINI:    r_etat <= ATTENTE;
        default: r_etat <= ATTENTE;
      endcase
    end
  end

  bin_vers_bcd u_bcd (
    .clk    (clk),
    .rst    (rst),
    .start  (w_go_bcd),
    .bin    (w_sum),
    .fini   (w_fini),
    .bcd100 (bcd100),
    .bcd10  (bcd10),
    .bcd1   (bcd1)
  );

  assign resultat = r_res;
  assign pret     = r_pret;
  assign occupe   = (r_etat == MODULO) | (r_etat == SOMME)
                  | (r_etat == BCD);

endmodule
